// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC, IF/ID register, stall/wait/redirect handling
// Optional feature macro: IF_BRANCH_DELAY_SLOT_EN (delay-slot branches, squash_ex tied low).
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_pc4,
    input  logic [15:0] ex_imm16,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic        squash_ex
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;

    logic [31:0] pc4;
    logic [31:0] br_target;

    assign pc4       = pc_q + 32'd4;
    assign br_target = ex_pc4 + {{14{ex_imm16[15]}}, ex_imm16, 2'b00};

    // Redirect wins over stall and memory wait so a taken branch is never lost.
    always_comb begin
        pc_d       = pc_q;
        id_inst_d  = id_inst_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
        if (ex_br_taken) begin
            pc_d       = br_target;
            id_inst_d  = 32'h0000_0000;
            id_pc4_d   = 32'h0000_0000;
            id_valid_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (!imem_ready) begin
            id_inst_d  = 32'h0000_0000;
            id_pc4_d   = 32'h0000_0000;
            id_valid_d = 1'b0;
        end else begin
            pc_d       = pc4;
            id_inst_d  = imem_data;
            id_pc4_d   = pc4;
            id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            id_inst_q  <= 32'h0000_0000;
            id_pc4_q   <= 32'h0000_0000;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_inst_q  <= id_inst_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign id_inst   = id_inst_q;
    assign id_pc4    = id_pc4_q;
    assign id_valid  = id_valid_q;

`ifdef IF_BRANCH_DELAY_SLOT_EN
    // The delay-slot instruction already in ID/EX must execute.
    assign squash_ex = 1'b0;
`else
    assign squash_ex = ex_br_taken;
`endif

endmodule
